// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning the HI/LO pair; emulates multi-cycle latency with a busy flag.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state, w_stateNext;
    logic [3:0]  r_count, w_countNext;
    logic [63:0] r_pend, w_pendNext;
    logic        r_commit, w_commitNext;
    logic        r_busy;
    logic [31:0] r_hi, w_hiNext;
    logic [31:0] r_lo, w_loNext;

    logic [63:0] w_prodS, w_prodU;
    logic [31:0] w_bSafe, w_quotS, w_remS, w_quotU, w_remU;

    // Full-width products: the low 64 bits of a sign-extended product equal the signed product.
    assign w_prodS = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prodU = {32'd0, i_a} * {32'd0, i_b};

    // A zero divisor never commits, so a dummy divisor of 1 just keeps the divider well-defined.
    assign w_bSafe = (i_b == 32'd0) ? 32'd1 : i_b;
    assign w_quotS = $signed(i_a) / $signed(w_bSafe);
    assign w_remS  = $signed(i_a) % $signed(w_bSafe);
    assign w_quotU = i_a / w_bSafe;
    assign w_remU  = i_a % w_bSafe;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    assign w_acc = {r_hi, r_lo};
`endif

    always_comb begin
        w_stateNext  = r_state;
        w_countNext  = r_count;
        w_pendNext   = r_pend;
        w_commitNext = r_commit;
        w_hiNext     = r_hi;
        w_loNext     = r_lo;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    case (i_op)
                        OP_MULT, OP_MULTU: begin
                            w_pendNext   = (i_op == OP_MULT) ? w_prodS : w_prodU;
                            w_commitNext = 1'b1;
                            w_countNext  = MULT_CNT;
                            w_stateNext  = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_pendNext   = (i_op == OP_DIV) ? {w_remS, w_quotS} : {w_remU, w_quotU};
                            w_commitNext = (i_b != 32'd0);
                            w_countNext  = DIV_CNT;
                            w_stateNext  = BUSY;
                        end
                        OP_MTHI: w_hiNext = i_a;
                        OP_MTLO: w_loNext = i_a;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            case (i_op)
                                OP_MADD:  w_pendNext = w_acc + w_prodS;
                                OP_MADDU: w_pendNext = w_acc + w_prodU;
                                OP_MSUB:  w_pendNext = w_acc - w_prodS;
                                default:  w_pendNext = w_acc - w_prodU;
                            endcase
                            w_commitNext = 1'b1;
                            w_countNext  = MULT_CNT;
                            w_stateNext  = BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                w_countNext = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_stateNext = IDLE;
                    if (r_commit) begin
                        w_hiNext = r_pend[63:32];
                        w_loNext = r_pend[31:0];
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_count  <= 4'd0;
            r_pend   <= 64'd0;
            r_commit <= 1'b0;
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state  <= w_stateNext;
            r_count  <= w_countNext;
            r_pend   <= w_pendNext;
            r_commit <= w_commitNext;
            r_busy   <= (w_stateNext == BUSY);
            r_hi     <= w_hiNext;
            r_lo     <= w_loNext;
        end
    end

    assign o_busy = r_busy;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and busy length are queued at issue, checked at completion.
// Accumulate-op expectations follow MDU_MADD_EN.
module tb_mdu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [3:0]  i_op;
    logic [31:0] i_a, i_b;
    logic        o_busy;
    logic [31:0] o_hi, o_lo;

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the start edge is the next rising edge, returns one falling edge later.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(negedge i_clk);
        i_start = 1'b0;
        i_op    = 4'd0;
        i_a     = $urandom;
        i_b     = $urandom;
    endtask

    task automatic collect();
        int   n = 0;
        exp_t e;
        while (o_busy && n < 40) begin
            n++;
            @(negedge i_clk);
        end
        e = sb.pop_front();
        checkOutput({e.tag, "_hi"}, {32'd0, o_hi}, {32'd0, e.hi});
        checkOutput({e.tag, "_lo"}, {32'd0, o_lo}, {32'd0, e.lo});
        checkOutput({e.tag, "_cycles"}, 64'(n), 64'(e.cycles));
    endtask

    task automatic runCmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eHi, input logic [31:0] eLo, input int eCyc, input string tag);
        exp_t e;
        e.tag = tag; e.hi = eHi; e.lo = eLo; e.cycles = eCyc;
        sb.push_back(e);
        applyStimulus(op, a, b);
        collect();
    endtask

    int          sa, sb2, q, r;
    longint      p;
    longint unsigned pu, ua, ub;
    logic [31:0] ra, rb;

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_op    = 4'd0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_busy", {63'd0, o_busy}, 64'd0);
        checkOutput("rst_hi", {32'd0, o_hi}, 64'd0);
        checkOutput("rst_lo", {32'd0, o_lo}, 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        runCmd(4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, "mult");
        runCmd(4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, "multu");
        runCmd(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div");
        runCmd(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu");

        // MTHI and MTLO on consecutive cycles.
        i_start = 1'b1; i_op = 4'd5; i_a = 32'h12345678;
        @(negedge i_clk);
        checkOutput("mthi_hi", {32'd0, o_hi}, {32'd0, 32'h12345678});
        checkOutput("mthi_busy", {63'd0, o_busy}, 64'd0);
        i_op = 4'd6; i_a = 32'h9ABCDEF0;
        @(negedge i_clk);
        i_start = 1'b0; i_op = 4'd0;
        checkOutput("mtlo_lo", {32'd0, o_lo}, {32'd0, 32'h9ABCDEF0});
        checkOutput("mtlo_busy", {63'd0, o_busy}, 64'd0);

        // MULT with an ignored DIV and MTHI issued while busy, then a back-to-back MULT.
        sb.push_back('{tag: "mult_ign", hi: 32'd0, lo: 32'd30, cycles: 5});
        applyStimulus(4'd1, 32'd5, 32'd6);
        @(negedge i_clk);
        i_start = 1'b1; i_op = 4'd3; i_a = 32'd1; i_b = 32'd1;
        @(negedge i_clk);
        i_op = 4'd5; i_a = 32'hDEADBEEF;
        @(negedge i_clk);
        i_start = 1'b0; i_op = 4'd0; i_a = $urandom; i_b = $urandom;
        checkOutput("hold_hi", {32'd0, o_hi}, {32'd0, 32'h12345678});
        checkOutput("hold_lo", {32'd0, o_lo}, {32'd0, 32'h9ABCDEF0});
        begin
            int   n = 3;
            exp_t e;
            while (o_busy && n < 40) begin
                n++;
                @(negedge i_clk);
            end
            e = sb.pop_front();
            checkOutput("mult_ign_hi", {32'd0, o_hi}, {32'd0, e.hi});
            checkOutput("mult_ign_lo", {32'd0, o_lo}, {32'd0, e.lo});
            checkOutput("mult_ign_cycles", 64'(n), 64'(e.cycles));
        end
        runCmd(4'd1, 32'd7, 32'd3, 32'd0, 32'd21, 5, "mult_b2b");

        // Divide by zero keeps HI/LO.
        runCmd(4'd5, 32'h11, 32'd0, 32'h11, 32'd21, 0, "mthi11");
        runCmd(4'd6, 32'h22, 32'd0, 32'h11, 32'h22, 0, "mtlo22");
        runCmd(4'd3, 32'd9, 32'd0, 32'h11, 32'h22, 10, "div0");

        // Reset in the fourth busy cycle of a MULT.
        applyStimulus(4'd1, 32'd3, 32'd4);
        repeat (3) @(negedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", {63'd0, o_busy}, 64'd0);
        checkOutput("midrst_hi", {32'd0, o_hi}, 64'd0);
        checkOutput("midrst_lo", {32'd0, o_lo}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (8) @(negedge i_clk);
        checkOutput("postrst_busy", {63'd0, o_busy}, 64'd0);
        checkOutput("postrst_lo", {32'd0, o_lo}, 64'd0);

        // Accumulate ops.
        runCmd(4'd6, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0, "mtlo_ff");
`ifdef MDU_MADD_EN
        runCmd(4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 5, "maddu");
`else
        runCmd(4'd8, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0, "maddu");
`endif
        runCmd(4'd5, 32'd0, 32'd0, 32'd0, o_lo, 0, "mthi_0");
        runCmd(4'd6, 32'd0, 32'd0, 32'd0, 32'd0, 0, "mtlo_0");
`ifdef MDU_MADD_EN
        runCmd(4'd9, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "msub");
`else
        runCmd(4'd9, 32'd1, 32'd1, 32'd0, 32'd0, 0, "msub");
`endif
        runCmd(4'd0, 32'h55, 32'h66, o_hi, o_lo, 0, "noop");

        // Randomised operands against an arithmetic model.
        for (int k = 0; k < 3; k++) begin
            ra = $urandom; rb = $urandom;
            sa = ra; sb2 = rb;
            p = longint'(sa) * longint'(sb2);
            runCmd(4'd1, ra, rb, p[63:32], p[31:0], 5, "rmult");
            ua = {32'd0, ra}; ub = {32'd0, rb};
            pu = ua * ub;
            runCmd(4'd2, ra, rb, pu[63:32], pu[31:0], 5, "rmultu");
            sb2 = int'($urandom_range(1, 1000));
            if (k == 1) sb2 = -sb2;
            rb = sb2;
            q = sa / sb2; r = sa % sb2;
            runCmd(4'd3, ra, rb, r, q, 10, "rdiv");
            runCmd(4'd4, ra, rb, ra % rb, ra / rb, 10, "rdivu");
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the HI/LO register pair in the pipelined MIPS core. It accepts one mult/div/move-to command per start pulse from the EX stage and emulates fixed multi-cycle latency with a busy flag that the hazard unit uses to stall HI/LO-dependent instructions. It owns the HI and LO registers that feed the write-back select path.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..15
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  command valid this cycle (one-cycle pulse from EX)
- op  input  4  command: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others no-op
- a  input  32  rs operand (forwarded value)
- b  input  32  rt operand (forwarded value)
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Reset (reset low, asynchronous): busy=0, hi=0, lo=0, counter=0, pending result=0, state IDLE.
- States: IDLE (counter==0), BUSY (counter!=0); busy = (counter!=0), registered.
- IDLE, start=1:
  - MULT/MULTU: pending {hi,lo} = a*b as 64-bit signed/unsigned product; counter<=MULT_CYCLES; -> BUSY.
  - DIV/DIVU: pending lo=a/b, hi=a%b (signed: quotient truncates toward zero, remainder takes sign of a); counter<=DIV_CYCLES; -> BUSY.
  - DIV/DIVU with b==0: full DIV_CYCLES busy period runs; hi/lo left unchanged at commit.
  - MTHI/MTLO: hi<=a or lo<=a at this edge; no busy; stay IDLE.
  - MADD/MADDU/MSUB/MSUBU: see Configuration; operands and current {hi,lo} captured at start edge.
  - Undefined op: no effect.
- BUSY: counter decrements each cycle; on edge where counter==1, hi/lo<=pending and counter->0 (IDLE).
- start=1 while BUSY: ignored entirely (including MTHI/MTLO); hazard unit guarantees none; bench checks hi/lo/counter unaffected.
- Operands a/b sampled only at start edge; changes during BUSY have no effect.
- Reset mid-BUSY: operation discarded, outputs return to reset values immediately.

## Timing
- start sampled at edge E0 (cycle T). busy=1 in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES).
- hi/lo updated at the edge ending cycle T+N; new values and busy=0 both visible in cycle T+N+1.
- start may be accepted again in cycle T+N+1 (back-to-back, no bubble).
- MTHI/MTLO: hi/lo new value visible in cycle T+1; busy stays 0.
- hi/lo readable every cycle; during BUSY they hold pre-operation values.

## Configuration
- MDU_MADD_EN defined: ops 7-10 run with MULT_CYCLES latency; pending {hi,lo} = {hi,lo} ± a*b (signed for MADD/MSUB, unsigned for MADDU/MSUBU), mod 2^64, using {hi,lo} as of the start edge.
- MDU_MADD_EN undefined: ops 7-10 treated as undefined (no busy, no hi/lo change); no accumulate logic synthesized.

## Test plan
- Reset then MULT a=0xFFFFFFFE(-2), b=3 -> busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo update next cycle each, busy never asserted.
- MULT a=5,b=6 then start DIV a=1,b=1 in the 3rd busy cycle, and change a/b during busy -> second command ignored; hi=0, lo=30; back-to-back MULT in cycle T+6 accepted.
- DIV a=9, b=0 with hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo remain 0x11/0x22; assert reset low in cycle 4 of another MULT -> busy/hi/lo to 0 immediately, no later commit.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0 after 5 cycles; MSUB a=1, b=1 from {0,0} -> hi=lo=0xFFFFFFFF. Without macro: same stimuli -> busy stays 0, hi/lo unchanged.
